// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
// Holds the FSM state encoding plus the default geometry and counter width.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 3;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
// A read and a write never happen on the same edge because the port is shared.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one access, stalls the pipeline for
// LATENCY cycles, then pulses done_o with load data or a misalignment flag.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic               accept;
    logic               entering_done;
    logic               acc_we;
    logic [IDX_W-1:0]   acc_idx;
    logic [1:0]         acc_off;
    logic [31:0]        acc_wdata;
    logic [31:0]        mem_rdata;
    logic               done_aligned;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^addr_i[31:IDX_W+2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        stall_o       = 1'b0;
        accept        = 1'b0;
        entering_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                    end else begin
                        state_next    = DONE;
                        entering_done = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next    = DONE;
                    entering_done = 1'b1;
                end
            end
            DONE: begin
                // req_i here still belongs to the completing access
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt     <= CNT_LOAD;
            we_q    <= we_i;
            addr_q  <= addr_i[IDX_W+1:0];
            wdata_q <= wdata_i;
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // With LATENCY=1 the array is touched on the accepting edge, before the latches hold the request
    assign acc_we    = accept ? we_i                : we_q;
    assign acc_idx   = accept ? addr_i[IDX_W+1:2]   : addr_q[IDX_W+1:2];
    assign acc_off   = accept ? addr_i[1:0]         : addr_q[1:0];
    assign acc_wdata = accept ? wdata_i             : wdata_q;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (entering_done && (acc_off == 2'b00)),
        .we_i    (acc_we),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    assign done_aligned = (state == DONE) && (addr_q[1:0] == 2'b00);
    assign done_o       = (state == DONE);
    assign err_o        = (state == DONE) && (addr_q[1:0] != 2'b00);
    assign rdata_o      = (done_aligned && !we_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 3 and 1) driven by directed and
// random accesses, checked every cycle against a transaction-level model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req   [2] = '{1'b0, 1'b0};
    logic        we    [2] = '{1'b0, 1'b0};
    logic [31:0] addr  [2] = '{32'h0, 32'h0};
    logic [31:0] wdata [2] = '{32'h0, 32'h0};
    logic        stall [2];
    logic        done  [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_i = ~clk_i;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i (clk_i), .rst_i (rst_i), .req_i (req[0]), .we_i (we[0]),
        .addr_i (addr[0]), .wdata_i (wdata[0]), .stall_o (stall[0]),
        .done_o (done[0]), .rdata_o (rdata[0]), .err_o (err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i (clk_i), .rst_i (rst_i), .req_i (req[1]), .we_i (we[1]),
        .addr_i (addr[1]), .wdata_i (wdata[1]), .stall_o (stall[1]),
        .done_o (done[1]), .rdata_o (rdata[1]), .err_o (err[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access per instance, completing at accept cycle + latency
    bit          pend      [2];
    int          done_cyc  [2];
    bit          m_we      [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_wdata   [2];
    logic [31:0] exp_rdata [2];
    bit          exp_err   [2];
    bit          exp_known [2];
    logic [31:0] mem_m     [2][DEPTH];
    bit          mem_known [2][DEPTH];

    always @(posedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_i) begin
                pend[d] = 1'b0;
            end else begin
                if (pend[d] && cyc == done_cyc[d]) begin
                    pend[d] = 1'b0;
                end else if (!pend[d] && req[d]) begin
                    pend[d]     = 1'b1;
                    done_cyc[d] = cyc + lat(d);
                    m_we[d]     = we[d];
                    m_addr[d]   = addr[d];
                    m_wdata[d]  = wdata[d];
                end
                if (pend[d] && cyc == done_cyc[d] - 1) begin
                    int idx;
                    idx          = (m_addr[d] / 4) % DEPTH;
                    exp_err[d]   = (m_addr[d] % 4) != 0;
                    exp_rdata[d] = 32'h0;
                    exp_known[d] = 1'b1;
                    if (!exp_err[d]) begin
                        if (m_we[d]) begin
                            mem_m[d][idx]     = m_wdata[d];
                            mem_known[d][idx] = 1'b1;
                        end else begin
                            exp_rdata[d] = mem_m[d][idx];
                            exp_known[d] = mem_known[d][idx];
                        end
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk_i) begin
        bit in_done;
        bit e_stall;
        for (int d = 0; d < 2; d++) begin
            in_done = rst_i && pend[d] && (cyc == done_cyc[d]);
            e_stall = (rst_i && pend[d]) ? !in_done : req[d];
            checkOutput($sformatf("stall%0d", d), {31'b0, stall[d]}, {31'b0, e_stall});
            checkOutput($sformatf("done%0d", d), {31'b0, done[d]}, {31'b0, in_done});
            checkOutput($sformatf("err%0d", d), {31'b0, err[d]}, {31'b0, in_done && exp_err[d]});
            if (!in_done || exp_known[d])
                checkOutput($sformatf("rdata%0d", d), rdata[d], in_done ? exp_rdata[d] : 32'h0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the done pulse with req dropped
    task automatic applyStimulus(input int d, input bit w, input logic [31:0] a,
                                 input logic [31:0] wd, input int drop_after,
                                 output logic [31:0] rd, output logic e, output int stalls);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        stalls = 0;
        rd = 32'h0;
        e = 1'b0;
        req[d] = 1'b1;
        we[d] = w;
        addr[d] = a;
        wdata[d] = wd;
        while (!seen && n < 64) begin
            @(negedge clk_i);
            n++;
            if (stall[d]) stalls++;
            if (done[d]) begin
                seen = 1'b1;
                rd = rdata[d];
                e = err[d];
            end else if (drop_after > 0 && n == drop_after) begin
                #2 req[d] = 1'b0;
            end
        end
        checkOutput("done_within_budget", {31'b0, seen}, 32'h1);
        @(posedge clk_i);
        #1;
        req[d] = 1'b0;
        we[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          st;
        logic [31:0] a;

        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_done", {31'b0, done[0]}, 32'h0);
        checkOutput("reset_stall", {31'b0, stall[0]}, 32'h0);
        checkOutput("reset_rdata", rdata[0], 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                applyStimulus(d, 1'b1, 32'(i * 4), $urandom, 0, rd, e, st);

        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, rd, e, st);
        checkOutput("store_stall_cycles", 32'(st), 32'd3);
        checkOutput("store_err", {31'b0, e}, 32'h0);
        checkOutput("store_rdata_zero", rd, 32'h0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 0, rd, e, st);
        checkOutput("load_deadbeef", rd, 32'hDEADBEEF);

        applyStimulus(0, 1'b1, 32'h400, 32'h11112222, 0, rd, e, st);
        applyStimulus(0, 1'b1, 32'h403, 32'h12345678, 0, rd, e, st);
        checkOutput("misaligned_err", {31'b0, e}, 32'h1);
        checkOutput("misaligned_rdata", rd, 32'h0);
        applyStimulus(0, 1'b0, 32'h400, 32'h0, 0, rd, e, st);
        checkOutput("misaligned_no_write", rd, 32'h11112222);

        applyStimulus(0, 1'b1, 32'h404, 32'hA5A5A5A5, 0, rd, e, st);
        applyStimulus(0, 1'b0, 32'h004, 32'h0, 0, rd, e, st);
        checkOutput("wrap_load", rd, 32'hA5A5A5A5);

        applyStimulus(0, 1'b1, 32'h20, 32'h11111111, 0, rd, e, st);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
        @(negedge clk_i);
        @(negedge clk_i);
        #1 rst_i = 1'b0; req[0] = 1'b0;
        #1;
        checkOutput("rst_wait_stall", {31'b0, stall[0]}, 32'h0);
        checkOutput("rst_wait_done", {31'b0, done[0]}, 32'h0);
        checkOutput("rst_wait_rdata", rdata[0], 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 0, rd, e, st);
        checkOutput("rst_store_discarded", rd, 32'h11111111);

        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2, rd, e, st);
        checkOutput("drop_req_rdata", rd, 32'hDEADBEEF);
        checkOutput("drop_req_stalls", 32'(st), 32'd3);

        applyStimulus(1, 1'b1, 32'h10, 32'hCAFEF00D, 0, rd, e, st);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 0, rd, e, st);
        checkOutput("lat1_stall_cycles", 32'(st), 32'd1);
        checkOutput("lat1_rdata", rd, 32'hCAFEF00D);
        @(negedge clk_i);
        checkOutput("lat1_single_pulse", {31'b0, done[1]}, 32'h0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 500; i++) begin
            int d;
            d = i % 2;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            applyStimulus(d, 1'($urandom_range(0, 1)), a, $urandom,
                          (d == 0 && $urandom_range(0, 3) == 0) ? 2 : 0, rd, e, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i);
                #1;
            end
        end

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 3: cycles from request presentation to done_o, legal range 1..15.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  MEM-stage access request; the requester holds it while stall_o=1.
REQ-006 SHALL have port we_i  input  1  1=store, 0=load; sampled at acceptance.
REQ-007 SHALL have port addr_i  input  32  byte address; sampled at acceptance.
REQ-008 SHALL have port wdata_i  input  32  store data; sampled at acceptance.
REQ-009 SHALL have port stall_o  output  1  pipeline freeze request to the IF/ID/EX/MEM registers.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata_o  output  32  load data toward the MEM/WB register, valid while done_o=1.
REQ-012 SHALL have port err_o  output  1  misaligned-access flag, valid while done_o=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 In IDLE with req_i=1, SHALL accept the request at the next edge: latch we_i, addr_i, wdata_i; load the counter with LATENCY-1; go to WAIT if LATENCY>1, else to DONE.
REQ-015 In IDLE with req_i=0, SHALL remain in IDLE with no memory side effects.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 1.
REQ-017 SHALL drive done_o=1 only in DONE, so done_o rises exactly LATENCY cycles after the IDLE cycle in which req_i was first seen.
REQ-018 DONE SHALL always return to IDLE at the next edge; req_i in DONE SHALL be ignored, because it belongs to the completing request.
REQ-019 stall_o SHALL be combinational: 1 when (IDLE and req_i=1) or WAIT; 0 in DONE and in idle-without-request.
REQ-020 Word index SHALL be latched addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-021 An aligned store SHALL write wdata into the array on the edge entering DONE; rdata_o SHALL be 0 in that DONE cycle.
REQ-022 An aligned load SHALL register array[index] into rdata_o on the edge entering DONE, reflecting all previously completed stores.
REQ-023 Misaligned access (latched addr[1:0]!=0) SHALL complete with normal timing: err_o=1, rdata_o=0, no array write.
REQ-024 Outside DONE, done_o, err_o, rdata_o SHALL be 0.
REQ-025 If req_i drops during WAIT, the accepted transaction SHALL still complete; abort is not supported.

Reset
REQ-026 rst_i=0 SHALL force IDLE, counter=0, done_o=0, err_o=0, rdata_o=0, and clear latched request registers, all asynchronously.
REQ-027 Reset during WAIT or DONE SHALL discard the pending access; a pending store SHALL NOT commit.
REQ-028 Array contents SHALL NOT be reset; after reset, the first accepted request SHALL be accepted from IDLE.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE/WAIT/DONE), DEFAULT_DEPTH=256, DEFAULT_LATENCY=3, and the counter width constant (4 bits).
REQ-030 The storage array SHALL be a sub-module dmem_array: single port, synchronous write, registered read, no reset.

Verification
REQ-031 After reset, store: addr=0x10, wdata=0xDEADBEEF, LATENCY=3 -> stall_o=1 for 3 cycles, done_o in cycle 3, err_o=0; then load 0x10 -> rdata_o=0xDEADBEEF with done_o.
REQ-032 LATENCY=1, load 0x10 -> stall_o=1 one cycle, done_o next cycle; back-to-back request held in DONE is not double-accepted (single pulse).
REQ-033 Store 0x12345678 to addr=0x403 -> done_o=1, err_o=1, no write; load 0x400 returns prior contents.
REQ-034 DEPTH=256: store 0xA5A5A5A5 to addr=0x404 -> load addr=0x004 returns 0xA5A5A5A5 (wrap).
REQ-035 Store 0x55 to 0x20, assert rst_i=0 in WAIT -> outputs 0 immediately, FSM IDLE; load 0x20 returns old value, not 0x55.
REQ-036 Drop req_i in WAIT during a load -> done_o still pulses at cycle LATENCY with correct data.
